// File: rtl/key_reset_ctrl.sv
// key_reset_ctrl: synchronised, debounced key channels with press strobes, toggles and a retriggerable stretched reset
module key_reset_ctrl #(
    parameter int                  NUM_KEYS        = 4,
    parameter int                  DEBOUNCE_CYCLES = 1000000,
    parameter int                  DB_W            = 20,
    parameter logic [NUM_KEYS-1:0] TOGGLE_MASK     = NUM_KEYS'(4'b0001),
    parameter int                  RST_KEY         = 0,
    parameter int                  RST_HOLD        = 16,
    parameter int                  HOLD_W          = 8
) (
    input  logic                clk_50M,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_toggle,
    output logic                sys_rst
);
    logic [NUM_KEYS-1:0] s1, s2, sync, accept, pressed;
    logic [HOLD_W-1:0]   hold;
    assign sync    = ~s2;
    assign pressed = accept & sync;
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        logic [DB_W-1:0] cnt;
        assign accept[i] = (sync[i] != key_state[i]) && (cnt == DB_W'(DEBOUNCE_CYCLES - 1));
        always_ff @(posedge clk_50M)
            if (!rst_n || sync[i] == key_state[i] || accept[i]) cnt <= '0;
            else cnt <= cnt + 1'b1;
    end
    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            s1         <= '1;
            s2         <= '1;
            key_state  <= '0;
            key_press  <= '0;
            key_toggle <= '0;
            sys_rst    <= 1'b0;
            hold       <= '0;
        end else begin
            s1         <= key;
            s2         <= s1;
            key_state  <= key_state ^ accept;
            key_press  <= pressed;
            key_toggle <= key_toggle ^ (pressed & TOGGLE_MASK);
            // hold counts the remaining high cycles after the current one; a press reloads it
            if (pressed[RST_KEY]) begin
                sys_rst <= 1'b1;
                hold    <= HOLD_W'(RST_HOLD - 1);
            end else begin
                sys_rst <= hold != '0;
                hold    <= hold - HOLD_W'(hold != '0);
            end
        end
    end
endmodule

// File: tb/tb_key_reset_ctrl.sv
// tb_key_reset_ctrl: directed checks of debounce, strobes, toggles and sys_rst stretching/retrigger
module tb_key_reset_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key = 4'hF;
    logic [3:0] st, pr, tg, st2, pr2, tg2;
    logic       sr, sr2;
    int         checks = 0, errors = 0, npress = 0;

    always #5 clk = ~clk;

    key_reset_ctrl #(.NUM_KEYS(4), .DEBOUNCE_CYCLES(8), .DB_W(20), .TOGGLE_MASK(4'b0001),
                     .RST_KEY(1), .RST_HOLD(4), .HOLD_W(8)) dut (
        .clk_50M(clk), .rst_n(rst_n), .key(key),
        .key_state(st), .key_press(pr), .key_toggle(tg), .sys_rst(sr));

    // long-hold copy so a second press can land inside an active window
    key_reset_ctrl #(.NUM_KEYS(4), .DEBOUNCE_CYCLES(8), .DB_W(20), .TOGGLE_MASK(4'b0001),
                     .RST_KEY(1), .RST_HOLD(64), .HOLD_W(8)) dut64 (
        .clk_50M(clk), .rst_n(rst_n), .key(key),
        .key_state(st2), .key_press(pr2), .key_toggle(tg2), .sys_rst(sr2));

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            npress += int'(pr[0]);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tick(3);
        chk("rst_state", st, 4'h0);
        chk("rst_press", pr, 4'h0);
        chk("rst_toggle", tg, 4'h0);
        chk("rst_sys", sr, 1'b0);
        chk("rst_sys64", sr2, 1'b0);

        rst_n = 1'b1;
        key = 4'b1110;
        tick(9);
        chk("k0_early_state", st, 4'h0);
        tick(1);
        chk("k0_state", st, 4'b0001);
        chk("k0_press", pr, 4'b0001);
        chk("k0_toggle", tg, 4'b0001);
        tick(1);
        chk("k0_press_low", pr, 4'b0000);
        key = 4'b1111;
        tick(9);
        chk("k0_rel_early", st, 4'b0001);
        tick(1);
        chk("k0_rel_state", st, 4'b0000);
        chk("k0_rel_nopress", pr, 4'b0000);

        key = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("bounce_nopress_a", pr, 4'b0000);
        end
        key = 4'b1111;
        tick(1);
        chk("bounce_nopress_b", pr, 4'b0000);
        key = 4'b1011;
        for (int i = 0; i < 9; i++) begin
            tick(1);
            chk("bounce_nopress_c", pr, 4'b0000);
            chk("bounce_state_low", st, 4'b0000);
        end
        tick(1);
        chk("bounce_state", st, 4'b0100);
        chk("bounce_press", pr, 4'b0100);
        chk("bounce_toggle", tg, 4'b0001);
        key = 4'b1111;
        tick(10);
        chk("bounce_rel", st, 4'b0000);

        npress = 0;
        key = 4'b1110;
        tick(20);
        chk("tog1", tg, 4'b0000);
        chk("tog1_state", st, 4'b0001);
        key = 4'b1111;
        tick(9);
        chk("tog_rel1_early", st, 4'b0001);
        tick(1);
        chk("tog_rel1", st, 4'b0000);
        tick(10);
        key = 4'b1110;
        tick(20);
        chk("tog2", tg, 4'b0001);
        key = 4'b1111;
        tick(9);
        chk("tog_rel2_early", st, 4'b0001);
        tick(1);
        chk("tog_rel2", st, 4'b0000);
        tick(10);
        chk("tog_npress", npress, 2);

        key = 4'b1101;
        tick(9);
        chk("sr_before", sr, 1'b0);
        tick(1);
        chk("sr_press", pr, 4'b0010);
        chk("sr_rise", sr, 1'b1);
        chk("sr64_rise", sr2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("sr_hold", sr, 1'b1);
        end
        tick(1);
        chk("sr_fall", sr, 1'b0);
        key = 4'b0101;
        tick(10);
        chk("k3_press", pr, 4'b1000);
        chk("k3_no_sr", sr, 1'b0);
        key = 4'b1111;
        tick(10);
        chk("k13_rel", st, 4'b0000);

        key = 4'b1101;
        tick(9);
        chk("rt_window_open", sr2, 1'b1);
        tick(1);
        chk("rt_press", pr2, 4'b0010);
        chk("rt_sys", sr2, 1'b1);
        tick(31);
        chk("rt_past_old_end", sr2, 1'b1);
        tick(32);
        chk("rt_last", sr2, 1'b1);
        tick(1);
        chk("rt_fall", sr2, 1'b0);
        key = 4'b1111;
        tick(10);

        key = 4'b1110;
        tick(7);
        rst_n = 1'b0;
        tick(1);
        chk("mid_db_state", st, 4'b0000);
        chk("mid_db_press", pr, 4'b0000);
        rst_n = 1'b1;
        tick(9);
        chk("mid_db_early", pr, 4'b0000);
        tick(1);
        chk("mid_db_repress", pr, 4'b0001);
        chk("mid_db_toggle", tg, 4'b0001);

        key = 4'b1100;
        tick(10);
        chk("mid_sr_press", pr, 4'b0010);
        chk("mid_sr_on", sr, 1'b1);
        tick(2);
        rst_n = 1'b0;
        tick(1);
        chk("mid_sr_state", st, 4'b0000);
        chk("mid_sr_toggle", tg, 4'b0000);
        chk("mid_sr_sys", sr, 1'b0);
        chk("mid_sr_sys64", sr2, 1'b0);
        rst_n = 1'b1;
        tick(9);
        chk("mid_sr_early", pr, 4'b0000);
        chk("mid_sr_quiet", sr, 1'b0);
        tick(1);
        chk("mid_sr_repress", pr, 4'b0011);
        chk("mid_sr_restate", st, 4'b0011);
        chk("mid_sr_resys", sr, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
